// File: rtl/id_ex_stage_reg_pkg.sv
// Shared ID/EX definitions: opcodes, ALUOp encodings, the decode control bundle
// and the source-operand usage helpers shared with the forwarding unit.
package id_ex_stage_reg_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd4;
   localparam logic [5:0] OP_ADDIU = 6'd12;
   localparam logic [5:0] OP_SUBIU = 6'd13;
   localparam logic [5:0] OP_SW    = 6'd16;
   localparam logic [5:0] OP_LW    = 6'd17;

   localparam logic [1:0] ALUOP_ISUB = 2'b00;
   localparam logic [1:0] ALUOP_IADD = 2'b01;
   localparam logic [1:0] ALUOP_R    = 2'b10;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       alu_src;
      logic       mem_write;
      logic       mem_read;
      logic       mem_to_reg;
   } ctrl_t;

   localparam ctrl_t BUBBLE = '0;

   function automatic logic rs_used_f(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_ADDIU) || (op == OP_SUBIU) ||
             (op == OP_SW) || (op == OP_LW);
   endfunction

   function automatic logic rt_used_f(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use detector: flags a decode slot that reads the register a load in EX
// is about to write. Zero latency; no flow control of its own.
module load_use_detect
   import id_ex_stage_reg_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              ex_valid_i,
   input  logic              ex_mem_read_i,
   input  logic [REG_AW-1:0] ex_rt_i,
   input  logic              id_valid_i,
   input  logic [5:0]        id_opcode_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   output logic              rs_used_o,
   output logic              rt_used_o,
   output logic              hz_o
);

   logic rs_match;
   logic rt_match;

   assign rs_used_o = rs_used_f(id_opcode_i);
   assign rt_used_o = rt_used_f(id_opcode_i);
   assign rs_match  = rs_used_o && (id_rs_i == ex_rt_i);
   assign rt_match  = rt_used_o && (id_rt_i == ex_rt_i);

   // $zero is never really written, so a load targeting it cannot create a dependency
   assign hz_o = ex_valid_i && ex_mem_read_i && id_valid_i && (ex_rt_i != '0) &&
                 (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion; 1-cycle latency, freezes on ex_hold,
// stalls PC/IF-ID combinationally via stall_out. Optional counters under ID_EX_PERF_EN.
module id_ex_stage_reg
   import id_ex_stage_reg_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [5:0]        id_opcode,
   input  logic              id_reg_write,
   input  logic              id_reg_dst,
   input  logic              id_alu_src,
   input  logic              id_mem_write,
   input  logic              id_mem_read,
   input  logic              id_mem_to_reg,
   input  logic [1:0]        id_alu_op,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              flush,
   input  logic              ex_hold,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_reg_dst,
   output logic              ex_alu_src,
   output logic              ex_mem_write,
   output logic              ex_mem_read,
   output logic              ex_mem_to_reg,
   output logic [1:0]        ex_alu_op,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic              stall_out
`ifdef ID_EX_PERF_EN
   ,
   output logic [31:0]       perf_bubbles,
   output logic [31:0]       perf_flushes
`endif
);

   typedef struct packed {
      logic              valid;
      ctrl_t             ctrl;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
   } stage_t;

   stage_t stage_q;
   stage_t stage_d;
   stage_t id_stage;
   logic   rs_used;
   logic   rt_used;
   logic   hz;

   load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
      .ex_valid_i    (stage_q.valid),
      .ex_mem_read_i (stage_q.ctrl.mem_read),
      .ex_rt_i       (stage_q.rt),
      .id_valid_i    (id_valid),
      .id_opcode_i   (id_opcode),
      .id_rs_i       (id_rs),
      .id_rt_i       (id_rt),
      .rs_used_o     (rs_used),
      .rt_used_o     (rt_used),
      .hz_o          (hz)
   );

   assign stall_out = hz || ex_hold;

   always_comb begin
      id_stage.valid           = id_valid;
      id_stage.ctrl.reg_write  = id_reg_write;
      id_stage.ctrl.alu_op     = id_alu_op;
      id_stage.ctrl.reg_dst    = id_reg_dst;
      id_stage.ctrl.alu_src    = id_alu_src;
      id_stage.ctrl.mem_write  = id_mem_write;
      id_stage.ctrl.mem_read   = id_mem_read;
      id_stage.ctrl.mem_to_reg = id_mem_to_reg;
      id_stage.rs_data         = id_rs_data;
      id_stage.rt_data         = id_rt_data;
      id_stage.imm             = id_imm;
      id_stage.rs              = id_rs;
      id_stage.rt              = id_rt;
      id_stage.rd              = id_rd;
      // an empty decode slot must never carry side-effecting control into EX
      if (!id_valid) begin
         id_stage.ctrl = BUBBLE;
      end
   end

   always_comb begin
      stage_d = stage_q;
      if (flush) begin
         stage_d = '0;
      end else if (ex_hold) begin
         stage_d = stage_q;
      end else if (hz) begin
         stage_d = '0;
      end else begin
         stage_d = id_stage;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign ex_valid      = stage_q.valid;
   assign ex_reg_write  = stage_q.ctrl.reg_write;
   assign ex_alu_op     = stage_q.ctrl.alu_op;
   assign ex_reg_dst    = stage_q.ctrl.reg_dst;
   assign ex_alu_src    = stage_q.ctrl.alu_src;
   assign ex_mem_write  = stage_q.ctrl.mem_write;
   assign ex_mem_read   = stage_q.ctrl.mem_read;
   assign ex_mem_to_reg = stage_q.ctrl.mem_to_reg;
   assign ex_rs_data    = stage_q.rs_data;
   assign ex_rt_data    = stage_q.rt_data;
   assign ex_imm        = stage_q.imm;
   assign ex_rs         = stage_q.rs;
   assign ex_rt         = stage_q.rt;
   assign ex_rd         = stage_q.rd;

`ifdef ID_EX_PERF_EN
   logic [31:0] perf_bubbles_q;
   logic [31:0] perf_bubbles_d;
   logic [31:0] perf_flushes_q;
   logic [31:0] perf_flushes_d;
   logic        bubble_load;

   // only count a bubble when it is actually written, not while a hold defers it
   assign bubble_load = hz && !flush && !ex_hold;

   always_comb begin
      perf_bubbles_d = perf_bubbles_q;
      perf_flushes_d = perf_flushes_q;
      if (bubble_load && (perf_bubbles_q != '1)) begin
         perf_bubbles_d = perf_bubbles_q + 32'd1;
      end
      if (flush && (perf_flushes_q != '1)) begin
         perf_flushes_d = perf_flushes_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_bubbles_q <= '0;
         perf_flushes_q <= '0;
      end else begin
         perf_bubbles_q <= perf_bubbles_d;
         perf_flushes_q <= perf_flushes_d;
      end
   end

   assign perf_bubbles = perf_bubbles_q;
   assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: each vector queues its expected EX contents and stall,
// and independent monitors pop and compare as the DUT presents them.
module tb_id_ex_stage_reg;
   import id_ex_stage_reg_pkg::*;

   localparam int E_LOAD = 0;
   localparam int E_ZERO = 1;
   localparam int E_KEEP = 2;

   typedef struct packed {
      logic        valid;
      logic [5:0]  op;
      ctrl_t       ctrl;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } instr_t;

   typedef struct packed {
      logic        valid;
      ctrl_t       ctrl;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } ex_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid = 1'b0;
   logic [5:0]  id_opcode = '0;
   logic        id_reg_write = 1'b0, id_reg_dst = 1'b0, id_alu_src = 1'b0;
   logic        id_mem_write = 1'b0, id_mem_read = 1'b0, id_mem_to_reg = 1'b0;
   logic [1:0]  id_alu_op = '0;
   logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
   logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
   logic        flush = 1'b0, ex_hold = 1'b0;
   logic        ex_valid, ex_reg_write, ex_reg_dst, ex_alu_src;
   logic        ex_mem_write, ex_mem_read, ex_mem_to_reg;
   logic [1:0]  ex_alu_op;
   logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic        stall_out;
`ifdef ID_EX_PERF_EN
   logic [31:0] perf_bubbles, perf_flushes;
`endif

   int   n_checks = 0;
   int   n_pass = 0;
   ex_t  out_q[$];
   logic stall_q[$];
   ex_t  last_exp = '0;

   always #5 clk = ~clk;

   id_ex_stage_reg dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_reg_write(id_reg_write), .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src),
      .id_mem_write(id_mem_write), .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
      .id_alu_op(id_alu_op), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .flush(flush), .ex_hold(ex_hold), .ex_valid(ex_valid),
      .ex_reg_write(ex_reg_write), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
      .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_alu_op(ex_alu_op), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .stall_out(stall_out)
`ifdef ID_EX_PERF_EN
      , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // decode-unit controls as the upstream decoder would produce them
   function automatic instr_t mk(input logic v, input logic [5:0] op, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [31:0] imm);
      instr_t i;
      i = '0;
      i.valid = v; i.op = op; i.rs = rs; i.rt = rt; i.rd = rd; i.imm = imm;
      i.rs_data = 32'h1000 + 32'(rs);
      i.rt_data = 32'h2000 + 32'(rt);
      case (op)
         OP_RTYPE: i.ctrl = '{reg_write: 1'b1, alu_op: ALUOP_R, reg_dst: 1'b1, default: 1'b0};
         OP_ADDIU: i.ctrl = '{reg_write: 1'b1, alu_op: ALUOP_IADD, alu_src: 1'b1, default: 1'b0};
         OP_SUBIU: i.ctrl = '{reg_write: 1'b1, alu_op: ALUOP_ISUB, alu_src: 1'b1, default: 1'b0};
         OP_SW:    i.ctrl = '{alu_op: ALUOP_IADD, alu_src: 1'b1, mem_write: 1'b1, default: 1'b0};
         OP_LW:    i.ctrl = '{reg_write: 1'b1, alu_op: ALUOP_IADD, alu_src: 1'b1,
                              mem_read: 1'b1, mem_to_reg: 1'b1, default: 1'b0};
         default:  i.ctrl = '0;
      endcase
      return i;
   endfunction

   task automatic step(input logic r, input logic fl, input logic hd, input instr_t in,
                       input logic chk, input logic es, input int ek);
      ex_t e;
      @(negedge clk);
      rst = r; flush = fl; ex_hold = hd;
      id_valid = in.valid; id_opcode = in.op;
      id_reg_write = in.ctrl.reg_write; id_alu_op = in.ctrl.alu_op;
      id_reg_dst = in.ctrl.reg_dst; id_alu_src = in.ctrl.alu_src;
      id_mem_write = in.ctrl.mem_write; id_mem_read = in.ctrl.mem_read;
      id_mem_to_reg = in.ctrl.mem_to_reg;
      id_rs_data = in.rs_data; id_rt_data = in.rt_data; id_imm = in.imm;
      id_rs = in.rs; id_rt = in.rt; id_rd = in.rd;
      if (ek == E_LOAD) begin
         e.valid = in.valid; e.ctrl = in.valid ? in.ctrl : '0;
         e.rs_data = in.rs_data; e.rt_data = in.rt_data; e.imm = in.imm;
         e.rs = in.rs; e.rt = in.rt; e.rd = in.rd;
      end else if (ek == E_ZERO) begin
         e = '0;
      end else begin
         e = last_exp;
      end
      last_exp = e;
      out_q.push_back(e);
      if (chk) stall_q.push_back(es);
   endtask

   // stall monitor: combinational, sampled mid-low-phase after inputs settle
   initial forever begin
      @(negedge clk); #2;
      if (stall_q.size() != 0) check("stall_out", 128'(stall_out), 128'(stall_q.pop_front()));
   end

   // EX register monitor: sampled just after the capturing edge
   initial forever begin
      ex_t act, exp;
      @(posedge clk); #1;
      if (out_q.size() != 0) begin
         exp = out_q.pop_front();
         act = {ex_valid, ex_reg_write, ex_alu_op, ex_reg_dst, ex_alu_src, ex_mem_write,
                ex_mem_read, ex_mem_to_reg, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd};
         check("ex_valid_ctrl", 128'({act.valid, act.ctrl}), 128'({exp.valid, exp.ctrl}));
         check("ex_data_spec", 128'({act.rs_data, act.rt_data, act.imm, act.rs, act.rt, act.rd}),
               128'({exp.rs_data, exp.rt_data, exp.imm, exp.rs, exp.rt, exp.rd}));
      end
   end

   initial begin
      instr_t nop;
      nop = mk(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      // reset with busy inputs
      step(1, 0, 0, mk(1, OP_ADDIU, 5'd1, 5'd2, 5'd3, 32'd9), 0, 0, E_ZERO);
      step(1, 0, 0, mk(1, OP_ADDIU, 5'd1, 5'd2, 5'd3, 32'd9), 1, 0, E_ZERO);
      // passthrough and load-use on rs
      step(0, 0, 0, mk(1, OP_ADDIU, 5'd1, 5'd2, 5'd0, 32'd5), 1, 0, E_LOAD);
      step(0, 0, 0, mk(1, OP_LW,    5'd1, 5'd3, 5'd0, 32'd8), 1, 0, E_LOAD);
      step(0, 0, 0, mk(1, OP_RTYPE, 5'd3, 5'd5, 5'd6, 32'd0), 1, 1, E_ZERO);
      step(0, 0, 0, mk(1, OP_RTYPE, 5'd3, 5'd5, 5'd6, 32'd0), 1, 0, E_LOAD);
      // no false hazards: unused rt, and $zero target
      step(0, 0, 0, mk(1, OP_LW,    5'd1, 5'd3, 5'd0, 32'd4), 1, 0, E_LOAD);
      step(0, 0, 0, mk(1, OP_ADDIU, 5'd4, 5'd3, 5'd0, 32'd7), 1, 0, E_LOAD);
      step(0, 0, 0, mk(1, OP_LW,    5'd2, 5'd0, 5'd0, 32'd4), 1, 0, E_LOAD);
      step(0, 0, 0, mk(1, OP_RTYPE, 5'd0, 5'd0, 5'd7, 32'd0), 1, 0, E_LOAD);
      // rt dependency through sw
      step(0, 0, 0, mk(1, OP_LW,    5'd1, 5'd9, 5'd0, 32'd12), 1, 0, E_LOAD);
      step(0, 0, 0, mk(1, OP_SW,    5'd2, 5'd9, 5'd0, 32'd16), 1, 1, E_ZERO);
      step(0, 0, 0, mk(1, OP_SW,    5'd2, 5'd9, 5'd0, 32'd16), 1, 0, E_LOAD);
      // back-to-back loads, one bubble per dependency
      step(0, 0, 0, mk(1, OP_LW,    5'd1, 5'd4, 5'd0, 32'd20), 1, 0, E_LOAD);
      step(0, 0, 0, mk(1, OP_LW,    5'd4, 5'd5, 5'd0, 32'd24), 1, 1, E_ZERO);
      step(0, 0, 0, mk(1, OP_LW,    5'd4, 5'd5, 5'd0, 32'd24), 1, 0, E_LOAD);
      step(0, 0, 0, mk(1, OP_RTYPE, 5'd5, 5'd1, 5'd2, 32'd0), 1, 1, E_ZERO);
      step(0, 0, 0, mk(1, OP_RTYPE, 5'd5, 5'd1, 5'd2, 32'd0), 1, 0, E_LOAD);
      // flush beats hold and hazard
      step(0, 0, 0, mk(1, OP_LW,    5'd1, 5'd6, 5'd0, 32'd28), 1, 0, E_LOAD);
      step(0, 1, 1, mk(1, OP_RTYPE, 5'd6, 5'd1, 5'd2, 32'd0), 1, 1, E_ZERO);
      // three-cycle hold with changing decode inputs
      step(0, 0, 0, mk(1, OP_LW,    5'd1, 5'd7, 5'd0, 32'd32), 1, 0, E_LOAD);
      step(0, 0, 1, mk(1, OP_RTYPE, 5'd8, 5'd9, 5'd1, 32'd0), 1, 1, E_KEEP);
      step(0, 0, 1, mk(1, OP_ADDIU, 5'd7, 5'd2, 5'd0, 32'd1), 1, 1, E_KEEP);
      step(0, 0, 1, mk(1, OP_SUBIU, 5'd3, 5'd4, 5'd0, 32'd2), 1, 1, E_KEEP);
      step(0, 0, 0, mk(1, OP_ADDIU, 5'd2, 5'd9, 5'd0, 32'd3), 1, 0, E_LOAD);
      // hazard under hold is deferred until hold drops
      step(0, 0, 0, mk(1, OP_LW,    5'd1, 5'd10, 5'd0, 32'd36), 1, 0, E_LOAD);
      step(0, 0, 1, mk(1, OP_RTYPE, 5'd10, 5'd0, 5'd3, 32'd0), 1, 1, E_KEEP);
      step(0, 0, 0, mk(1, OP_RTYPE, 5'd10, 5'd0, 5'd3, 32'd0), 1, 1, E_ZERO);
      step(0, 0, 0, mk(1, OP_RTYPE, 5'd10, 5'd0, 5'd3, 32'd0), 1, 0, E_LOAD);
      // invalid slots carry no control and raise no hazard
      step(0, 0, 0, mk(0, OP_LW,    5'd1, 5'd11, 5'd0, 32'd40), 1, 0, E_LOAD);
      step(0, 0, 0, mk(1, OP_LW,    5'd1, 5'd11, 5'd0, 32'd44), 1, 0, E_LOAD);
      step(0, 0, 0, mk(0, OP_RTYPE, 5'd11, 5'd1, 5'd2, 32'd0), 1, 0, E_LOAD);
`ifdef ID_EX_PERF_EN
      @(posedge clk); #1;
      check("perf_bubbles", 128'(perf_bubbles), 128'(5));
      check("perf_flushes", 128'(perf_flushes), 128'(1));
`endif
      // reset mid-stream clears a pending hazard
      step(0, 0, 0, mk(1, OP_LW,    5'd1, 5'd12, 5'd0, 32'd48), 1, 0, E_LOAD);
      step(1, 0, 0, mk(1, OP_RTYPE, 5'd12, 5'd1, 5'd2, 32'd0), 1, 1, E_ZERO);
      step(0, 0, 0, mk(1, OP_RTYPE, 5'd12, 5'd1, 5'd2, 32'd0), 1, 0, E_LOAD);
`ifdef ID_EX_PERF_EN
      @(posedge clk); #1;
      check("perf_after_rst", 128'({perf_bubbles, perf_flushes}), 128'(0));
`endif
      step(0, 0, 0, nop, 1, 0, E_LOAD);
      step(0, 0, 0, nop, 1, 0, E_LOAD);
      for (int i = 0; i < 10 && out_q.size() != 0; i++) @(posedge clk);
      #3;
      check("drain", 128'(out_q.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
